// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the base-SRAM arbiter: FSM states, port IDs
// and the wait-counter sizing helper.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  localparam logic [3:0] BE_NONE = 4'hF;
  localparam logic [3:0] BE_ALL  = 4'h0;

  // Counter must hold the longest reload value plus headroom for the last cycle.
  function automatic int wait_cnt_width(input int read_wait, input int write_wait);
    int longest;
    longest = (read_wait > write_wait) ? read_wait : write_wait;
    return $clog2(longest + 2);
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the CPU fetch and data ports onto the single asynchronous base SRAM
// and sequences its read/write timing, returning a one-cycle ack per access.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,

  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,

  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [31:0] ram_dout,
  output logic        ram_dout_oe,
  input  logic [31:0] ram_din
);

  localparam int CW = wait_cnt_width(READ_WAIT, WRITE_WAIT);
  localparam logic [CW-1:0] READ_RELOAD  = CW'(READ_WAIT);
  localparam logic [CW-1:0] WRITE_RELOAD = CW'(WRITE_WAIT);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_port;
  logic          gnt_port;

  logic          grant_any;
  logic          pick_port;
  logic          pick_write;
  logic [31:0]   pick_addr;
  logic          unused_addr_bits;

  // Round-robin between the two ports: on a conflict the port not served last wins.
  always_comb begin
    pick_port = PORT_IF;
    if (mem_req && (!if_req || last_port == PORT_IF))
      pick_port = PORT_MEM;
    grant_any  = if_req || mem_req;
    pick_write = (pick_port == PORT_MEM) && mem_we;
    pick_addr  = (pick_port == PORT_MEM) ? mem_addr : if_addr;
  end

  // Byte offset and the region-select bits are decoded upstream.
  assign unused_addr_bits = ^{pick_addr[31:22], pick_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      last_port   <= PORT_IF;
      gnt_port    <= PORT_IF;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_ack      <= 1'b0;
      mem_ack     <= 1'b0;
      ram_addr    <= '0;
      ram_be_n    <= BE_NONE;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_dout    <= '0;
      ram_dout_oe <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            last_port <= pick_port;
            gnt_port  <= pick_port;
            ram_addr  <= pick_addr[21:2];
            ram_ce_n  <= 1'b0;
            if (pick_write) begin
              state       <= ST_WR_SETUP;
              ram_be_n    <= ~mem_sel;
              ram_dout    <= mem_wdata;
              ram_dout_oe <= 1'b1;
              ram_oe_n    <= 1'b1;
              ram_we_n    <= 1'b1;
            end else begin
              state    <= ST_RD;
              ram_be_n <= BE_ALL;
              ram_oe_n <= 1'b0;
              wait_cnt <= READ_RELOAD;
            end
          end
        end

        ST_RD: begin
          if (wait_cnt == '0) begin
            if (gnt_port == PORT_IF) begin
              if_rdata <= ram_din;
              if_ack   <= 1'b1;
            end else begin
              mem_rdata <= ram_din;
              mem_ack   <= 1'b1;
            end
            state    <= ST_DONE;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_be_n <= BE_NONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ST_WR_SETUP: begin
          state    <= ST_WR_PULSE;
          ram_we_n <= 1'b0;
          wait_cnt <= WRITE_RELOAD;
        end

        ST_WR_PULSE: begin
          if (wait_cnt == '0) begin
            state    <= ST_WR_HOLD;
            ram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        // Data stays driven one cycle past the strobe so the SRAM sees stable hold time.
        ST_WR_HOLD: begin
          state       <= ST_DONE;
          ram_ce_n    <= 1'b1;
          ram_dout_oe <= 1'b0;
          ram_be_n    <= BE_NONE;
          if (gnt_port == PORT_IF) if_ack  <= 1'b1;
          else                     mem_ack <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          ram_ce_n    <= 1'b1;
          ram_oe_n    <= 1'b1;
          ram_we_n    <= 1'b1;
          ram_dout_oe <= 1'b0;
          ram_be_n    <= BE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed checks on a default-timing instance plus a
// randomized scoreboard run on a READ_WAIT=0 / WRITE_WAIT=3 instance.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  // Instance A: default timing
  logic        a_rst, a_if_req, a_if_ack, a_mem_req, a_mem_we, a_mem_ack;
  logic [31:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_sel, a_ram_be_n;
  logic [19:0] a_ram_addr;
  logic        a_ram_ce_n, a_ram_oe_n, a_ram_we_n, a_ram_dout_oe;
  logic [31:0] a_ram_dout, a_ram_din, a_din_reg;
  logic        a_din_mode;

  // Instance B: fast read, long write strobe
  logic        b_rst, b_if_req, b_if_ack, b_mem_req, b_mem_we, b_mem_ack;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_sel, b_ram_be_n;
  logic [19:0] b_ram_addr;
  logic        b_ram_ce_n, b_ram_oe_n, b_ram_we_n, b_ram_dout_oe;
  logic [31:0] b_ram_dout, b_ram_din;

  logic [31:0] sram_b [256];
  logic [31:0] ref_b  [256];

  // A's pins return a tag of the presented address so data routing is visible.
  assign a_ram_din = a_din_mode ? {12'hABC, a_ram_addr} : a_din_reg;
  assign b_ram_din = (!b_ram_ce_n && !b_ram_oe_n) ? sram_b[b_ram_addr[7:0]] : 32'hA5A5_5A5A;

  // Asynchronous SRAM commits on the rising edge of we_n while selected.
  always @(posedge b_ram_we_n) begin
    if (!b_ram_ce_n && b_ram_dout_oe)
      for (int l = 0; l < 4; l++)
        if (!b_ram_be_n[l]) sram_b[b_ram_addr[7:0]][8*l +: 8] = b_ram_dout[8*l +: 8];
  end

  sram_arbiter dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_sel(a_mem_sel),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
    .ram_addr(a_ram_addr), .ram_be_n(a_ram_be_n), .ram_ce_n(a_ram_ce_n), .ram_oe_n(a_ram_oe_n),
    .ram_we_n(a_ram_we_n), .ram_dout(a_ram_dout), .ram_dout_oe(a_ram_dout_oe), .ram_din(a_ram_din)
  );

  sram_arbiter #(.READ_WAIT(0), .WRITE_WAIT(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_sel(b_mem_sel),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .ram_addr(b_ram_addr), .ram_be_n(b_ram_be_n), .ram_ce_n(b_ram_ce_n), .ram_oe_n(b_ram_oe_n),
    .ram_we_n(b_ram_we_n), .ram_dout(b_ram_dout), .ram_dout_oe(b_ram_dout_oe), .ram_din(b_ram_din)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Invariants that must hold on every cycle of both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      check("a_ack_excl", {31'b0, a_if_ack & a_mem_ack}, 32'd0);
      check("a_oe_vs_doe", {31'b0, ~a_ram_oe_n & a_ram_dout_oe}, 32'd0);
      check("b_ack_excl", {31'b0, b_if_ack & b_mem_ack}, 32'd0);
      check("b_oe_vs_doe", {31'b0, ~b_ram_oe_n & b_ram_dout_oe}, 32'd0);
      if (a_if_ack || a_mem_ack) check("a_ce_in_done", {31'b0, a_ram_ce_n}, 32'd1);
      if (b_if_ack || b_mem_ack) check("b_ce_in_done", {31'b0, b_ram_ce_n}, 32'd1);
    end
  end

  int          we_low, doe_hi, ack_cycle, if_wait, mem_wait, if_idx, mem_idx;
  logic        if_pend, mem_pend, mem_is_wr;
  logic [19:0] if_word, mem_word;
  logic [3:0]  mem_sel_q;
  logic [31:0] mem_wdata_q, r, w;

  initial begin
    a_rst = 1'b1; a_if_req = 0; a_if_addr = 0; a_mem_req = 0; a_mem_we = 0;
    a_mem_addr = 0; a_mem_sel = 0; a_mem_wdata = 0; a_din_reg = 0; a_din_mode = 0;
    b_rst = 1'b1; b_if_req = 0; b_if_addr = 0; b_mem_req = 0; b_mem_we = 0;
    b_mem_addr = 0; b_mem_sel = 0; b_mem_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      sram_b[i] = w;
      ref_b[i]  = w;
    end

    // Reset held three cycles, then idle for twenty
    @(negedge clk);
    tick(3);
    a_rst = 1'b0; b_rst = 1'b0; mon_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("reset_pins", {22'b0, a_ram_ce_n, a_ram_oe_n, a_ram_we_n, a_ram_be_n,
                           a_ram_dout_oe, a_if_ack, a_mem_ack}, {22'b0, 3'b111, 4'hF, 3'b000});
    end
    check("reset_addr", {12'b0, a_ram_addr}, 32'd0);
    check("reset_if_rdata", a_if_rdata, 32'd0);
    check("reset_mem_rdata", a_mem_rdata, 32'd0);

    // Fetch read with default timing
    a_din_reg = 32'hDEADBEEF; a_if_addr = 32'h0000_0010; a_if_req = 1'b1;
    tick(1);
    check("if_rd_addr", {12'b0, a_ram_addr}, 32'h4);
    check("if_rd_c1", {28'b0, a_ram_oe_n, a_ram_ce_n, a_if_ack, a_mem_ack}, 32'h0);
    check("if_rd_be", {28'b0, a_ram_be_n}, 32'h0);
    tick(1);
    check("if_rd_c2", {29'b0, a_ram_oe_n, a_if_ack, a_mem_ack}, 32'h0);
    tick(1);
    check("if_rd_ack", {29'b0, a_ram_oe_n, a_if_ack, a_mem_ack}, 32'h6);
    check("if_rd_data", a_if_rdata, 32'hDEADBEEF);
    a_if_req = 1'b0; a_din_reg = 32'h0;
    tick(1);
    check("if_rd_after", {31'b0, a_if_ack}, 32'd0);
    check("if_rd_held", a_if_rdata, 32'hDEADBEEF);

    // Data write with partial byte enables
    a_mem_req = 1'b1; a_mem_we = 1'b1; a_mem_addr = 32'h0000_0104;
    a_mem_sel = 4'b0011; a_mem_wdata = 32'h1234_5678;
    we_low = 0; doe_hi = 0; ack_cycle = 0;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      if (!a_ram_we_n) we_low++;
      if (a_ram_dout_oe) doe_hi++;
      if (a_mem_ack && ack_cycle == 0) ack_cycle = c;
      if (c == 1) begin
        check("wr_be", {28'b0, a_ram_be_n}, 32'hC);
        check("wr_addr", {12'b0, a_ram_addr}, 32'h41);
        check("wr_dout", a_ram_dout, 32'h1234_5678);
      end
    end
    check("wr_we_low_cycles", we_low, 32'd2);
    check("wr_doe_cycles", doe_hi, 32'd4);
    check("wr_ack_cycle", ack_cycle, 32'd5);
    a_mem_req = 1'b0; a_mem_we = 1'b0;
    tick(1);
    check("wr_ack_gone", {31'b0, a_mem_ack}, 32'd0);
    check("wr_rdata_untouched", a_mem_rdata, 32'd0);

    // Conflicting requests right after reset alternate MEM, IF, MEM, IF
    a_rst = 1'b1;
    tick(2);
    a_rst = 1'b0; a_din_mode = 1'b1;
    a_if_addr = 32'h0000_0020; a_mem_addr = 32'h0000_0300; a_mem_we = 1'b0;
    a_if_req = 1'b1; a_mem_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick(1);
      check("arb_acks", {30'b0, a_if_ack, a_mem_ack},
            {30'b0, (c == 7 || c == 15), (c == 3 || c == 11)});
      if (c == 1) check("arb_first_addr", {12'b0, a_ram_addr}, 32'hC0);
      if (c == 5) check("arb_second_addr", {12'b0, a_ram_addr}, 32'h8);
      if (c == 3) check("arb_mem_data", a_mem_rdata, 32'hABC0_00C0);
      if (c == 7) check("arb_if_data", a_if_rdata, 32'hABC0_0008);
    end
    a_if_req = 1'b0; a_mem_req = 1'b0;
    tick(1);

    // Reset in the middle of the write strobe aborts without an ack
    a_mem_req = 1'b1; a_mem_we = 1'b1; a_mem_addr = 32'h8; a_mem_sel = 4'hF;
    a_mem_wdata = 32'hCAFE_F00D;
    tick(2);
    check("abort_in_pulse", {31'b0, a_ram_we_n}, 32'd0);
    a_rst = 1'b1; a_mem_req = 1'b0; a_mem_we = 1'b0;
    tick(1);
    check("abort_pins", {28'b0, a_ram_we_n, a_ram_ce_n, a_ram_dout_oe, a_mem_ack}, 32'hC);
    a_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      check("abort_quiet", {29'b0, a_ram_ce_n, a_if_ack, a_mem_ack}, 32'h4);
    end
    a_mem_req = 1'b1; a_mem_addr = 32'h0000_0044;
    tick(2);
    check("fresh_no_early_ack", {31'b0, a_mem_ack}, 32'd0);
    tick(1);
    check("fresh_ack", {31'b0, a_mem_ack}, 32'd1);
    check("fresh_data", a_mem_rdata, 32'hABC0_0011);
    a_mem_req = 1'b0;
    tick(1);

    // Instance B: read latency 2, write latency 7
    b_if_addr = 32'h0000_0208; b_if_req = 1'b1;
    tick(1);
    check("b_rd_early", {31'b0, b_if_ack}, 32'd0);
    tick(1);
    check("b_rd_ack", {31'b0, b_if_ack}, 32'd1);
    check("b_rd_data", b_if_rdata, ref_b[130]);
    b_if_req = 1'b0;
    tick(1);
    b_mem_req = 1'b1; b_mem_we = 1'b1; b_mem_addr = 32'h0000_0014;
    b_mem_sel = 4'b1010; b_mem_wdata = 32'h89AB_CDEF;
    for (int c = 1; c <= 7; c++) begin
      tick(1);
      check("b_wr_ack_timing", {31'b0, b_mem_ack}, {31'b0, (c == 7)});
    end
    ref_b[5][31:24] = 8'h89;
    ref_b[5][15:8]  = 8'hCD;
    b_mem_req = 1'b0; b_mem_we = 1'b0;
    tick(1);
    b_mem_req = 1'b1;
    tick(2);
    check("b_rb_ack", {31'b0, b_mem_ack}, 32'd1);
    check("b_rb_data", b_mem_rdata, ref_b[5]);
    b_mem_req = 1'b0;
    tick(1);

    // Random concurrent traffic; fetches read the upper half, data uses the lower half
    if_pend = 0; mem_pend = 0; if_wait = 0; mem_wait = 0;
    if_idx = 0; mem_idx = 0; if_word = 0; mem_word = 0;
    mem_is_wr = 0; mem_sel_q = 0; mem_wdata_q = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick(1);
      if (b_if_ack) begin
        check("b_if_ack_pending", {31'b0, if_pend}, 32'd1);
        check("b_if_rdata", b_if_rdata, ref_b[if_idx]);
        check("b_if_ram_addr", {12'b0, b_ram_addr}, {12'b0, if_word});
        if_pend = 0; b_if_req = 1'b0;
      end
      if (b_mem_ack) begin
        check("b_mem_ack_pending", {31'b0, mem_pend}, 32'd1);
        check("b_mem_ram_addr", {12'b0, b_ram_addr}, {12'b0, mem_word});
        if (mem_is_wr) begin
          for (int l = 0; l < 4; l++)
            if (mem_sel_q[l]) ref_b[mem_idx][8*l +: 8] = mem_wdata_q[8*l +: 8];
        end else begin
          check("b_mem_rdata", b_mem_rdata, ref_b[mem_idx]);
        end
        mem_pend = 0; b_mem_req = 1'b0; b_mem_we = 1'b0;
      end
      if (if_pend && ++if_wait > 40) begin
        check("b_if_timeout", if_wait, 32'd40);
        if_pend = 0; b_if_req = 1'b0;
      end
      if (mem_pend && ++mem_wait > 40) begin
        check("b_mem_timeout", mem_wait, 32'd40);
        mem_pend = 0; b_mem_req = 1'b0;
      end
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        r = $urandom;
        if_idx = 128 + int'($urandom_range(0, 127));
        if_word = {r[19:8], 8'(if_idx)};
        b_if_addr = {r[31:22], if_word, r[1:0]};
        b_if_req = 1'b1; if_pend = 1; if_wait = 0;
      end
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        r = $urandom;
        mem_idx = int'($urandom_range(0, 127));
        mem_word = {r[19:8], 8'(mem_idx)};
        mem_is_wr = r[4];
        mem_sel_q = r[23:20];
        mem_wdata_q = $urandom;
        b_mem_addr = {r[31:22], mem_word, r[1:0]};
        b_mem_we = mem_is_wr; b_mem_sel = mem_sel_q; b_mem_wdata = mem_wdata_q;
        b_mem_req = 1'b1; mem_pend = 1; mem_wait = 0;
      end
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
